// File: rtl/uart_pkg.sv
// Shared defaults and the log2 helper for the parameterised UART FIFO.
package uart_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Returns the number of address bits needed for DEPTH entries.
  function automatic int log2c(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_fifo_param_if.sv
// FIFO request/status bundle; master drives requests, slave is the FIFO.
interface uart_fifo_param_if
  import uart_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) ();

  localparam int CW = log2c(DEPTH) + 1;

  logic              push;
  logic              pop;
  logic              flush;
  logic [DATA_W-1:0] data_in;
  logic [CW-1:0]     thresh;
  logic              clr_err;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CW-1:0]     count;
  logic              almost_full;
  logic              thresh_hit;
  logic              overrun;
  logic              underrun;

  modport master (
    output push, pop, flush, data_in, thresh, clr_err,
    input  data_out, rd_valid, fifo_empty, fifo_full, count,
           almost_full, thresh_hit, overrun, underrun
  );

  modport slave (
    input  push, pop, flush, data_in, thresh, clr_err,
    output data_out, rd_valid, fifo_empty, fifo_full, count,
           almost_full, thresh_hit, overrun, underrun
  );

endinterface

// File: rtl/uart_fifo_ram.sv
// FIFO storage: one write port and a registered read port that holds its value.
module uart_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk_in,
  input  logic              rstn,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage array is intentionally left without reset.
  always_ff @(posedge clk_in) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read register updates only on an accepted pop, otherwise holds.
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[raddr];
    end else begin
      r_rdata <= r_rdata;
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/uart_fifo_param.sv
// Parameterised synchronous FIFO with occupancy status and sticky error flags.
module uart_fifo_param
  import uart_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic           clk_in,
  input  logic           rstn,
  uart_fifo_param_if.slave bus
);

  localparam int AW = log2c(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] ALMOST_CNT = CW'(DEPTH - 1);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_rd_valid;
  logic          r_overrun;
  logic          r_underrun;

  logic          w_full;
  logic          w_empty;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic          w_ovr_evt;
  logic          w_udr_evt;
  logic [CW-1:0] w_count_nxt;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == {CW{1'b0}});

  // Acceptance: a pop on a full FIFO frees the slot for a same-cycle push.
  always_comb begin
    w_push_ok   = 1'b0;
    w_pop_ok    = 1'b0;
    w_ovr_evt   = 1'b0;
    w_udr_evt   = 1'b0;
    w_count_nxt = r_count;
    if (bus.flush) begin
      w_count_nxt = {CW{1'b0}};
    end else begin
      w_pop_ok  = bus.pop && !w_empty;
      w_push_ok = bus.push && (!w_full || w_pop_ok);
      w_ovr_evt = bus.push && w_full && !bus.pop;
      w_udr_evt = bus.pop && w_empty;
      if (w_push_ok && !w_pop_ok) begin
        w_count_nxt = r_count + CW'(1'b1);
      end else if (w_pop_ok && !w_push_ok) begin
        w_count_nxt = r_count - CW'(1'b1);
      end else begin
        w_count_nxt = r_count;
      end
    end
  end

  // Pointers, occupancy, read strobe and sticky flags.
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_rd_valid <= w_pop_ok;
      if (bus.flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push_ok) begin
          r_wptr <= r_wptr + AW'(1'b1);
        end
        if (w_pop_ok) begin
          r_rptr <= r_rptr + AW'(1'b1);
        end
      end
      // A fresh error event outranks a simultaneous clear.
      if (w_ovr_evt) begin
        r_overrun <= 1'b1;
      end else if (bus.clr_err) begin
        r_overrun <= 1'b0;
      end
      if (w_udr_evt) begin
        r_underrun <= 1'b1;
      end else if (bus.clr_err) begin
        r_underrun <= 1'b0;
      end
    end
  end

  uart_fifo_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_in(clk_in),
    .rstn  (rstn),
    .we    (w_push_ok),
    .waddr (r_wptr),
    .wdata (bus.data_in),
    .re    (w_pop_ok),
    .raddr (r_rptr),
    .rdata (bus.data_out)
  );

  assign bus.rd_valid    = r_rd_valid;
  assign bus.count       = r_count;
  assign bus.fifo_empty  = w_empty;
  assign bus.fifo_full   = w_full;
  assign bus.almost_full = (r_count >= ALMOST_CNT);
  assign bus.thresh_hit  = (bus.thresh != {CW{1'b0}}) && (r_count >= bus.thresh);
  assign bus.overrun     = r_overrun;
  assign bus.underrun    = r_underrun;

endmodule

// File: tb/tb_uart_fifo_param.sv
// Scoreboard bench: stimulus queues expected read data, a monitor checks each rd_valid.
module tb_uart_fifo_param;

  logic clk_in;
  logic rstn;

  int checks;
  int failures;

  logic [7:0] m_fifo [$];
  logic [7:0] exp_q  [$];
  int         m_cnt;

  uart_fifo_param_if #(.DATA_W(8), .DEPTH(16)) bus ();

  uart_fifo_param #(.DATA_W(8), .DEPTH(16)) dut (
    .clk_in(clk_in),
    .rstn  (rstn),
    .bus   (bus.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock of stimulus; the reference queue tracks accepted pushes and pops.
  task automatic drive(input bit p, input bit q, input bit f, input bit c, input logic [7:0] d);
    bit push_ok;
    bit pop_ok;
    bus.push    = p;
    bus.pop     = q;
    bus.flush   = f;
    bus.clr_err = c;
    bus.data_in = d;
    pop_ok  = q && !f && (m_cnt > 0);
    push_ok = p && !f && ((m_cnt < 16) || pop_ok);
    if (f) begin
      m_fifo.delete();
      m_cnt = 0;
    end else begin
      if (pop_ok) begin
        exp_q.push_back(m_fifo.pop_front());
        m_cnt--;
      end
      if (push_ok) begin
        m_fifo.push_back(d);
        m_cnt++;
      end
    end
    @(posedge clk_in);
    #1;
    chk("rd_valid_pulse", {31'd0, bus.rd_valid}, {31'd0, pop_ok});
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic push_w(input logic [7:0] d); drive(1'b1, 1'b0, 1'b0, 1'b0, d); endtask
  task automatic pop_w();                     drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00); endtask
  task automatic both_w(input logic [7:0] d); drive(1'b1, 1'b1, 1'b0, 1'b0, d); endtask

  // Monitor: every read strobe must match the oldest expected word.
  always @(negedge clk_in) begin
    if (rstn && bus.rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected actual=%0h required=none", bus.data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.data_out !== e) begin
          failures++;
          $display("FAIL rd_data actual=%0h required=%0h", bus.data_out, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    m_cnt    = 0;
    rstn        = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;
    bus.data_in = 8'h00;
    bus.thresh  = 5'd0;
    #12;
    chk("rst_count",   {27'd0, bus.count}, 32'd0);
    chk("rst_empty",   {31'd0, bus.fifo_empty}, 32'd1);
    chk("rst_full",    {31'd0, bus.fifo_full}, 32'd0);
    chk("rst_almost",  {31'd0, bus.almost_full}, 32'd0);
    chk("rst_dout",    {24'd0, bus.data_out}, 32'd0);
    chk("rst_flags",   {30'd0, bus.overrun, bus.underrun}, 32'd0);
    rstn = 1'b1;
    @(posedge clk_in);
    #1;

    // Fill with 0x11..0x1F then 0x10.
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] d;
      d = (i == 16) ? 8'h10 : 8'h10 + 8'(i);
      push_w(d);
      if (i == 14) chk("almost_at14", {31'd0, bus.almost_full}, 32'd0);
      if (i == 15) begin
        chk("almost_at15", {31'd0, bus.almost_full}, 32'd1);
        chk("full_at15",   {31'd0, bus.fifo_full}, 32'd0);
        chk("count_15",    {27'd0, bus.count}, 32'd15);
      end
    end
    chk("full_at16",  {31'd0, bus.fifo_full}, 32'd1);
    chk("count_16",   {27'd0, bus.count}, 32'd16);

    // Overrun on a lone push while full; 0xAA must never come out.
    push_w(8'hAA);
    chk("overrun_set",  {31'd0, bus.overrun}, 32'd1);
    chk("count_ovr",    {27'd0, bus.count}, 32'd16);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("overrun_clr",  {31'd0, bus.overrun}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      pop_w();
      if (i == 0) chk("first_pop", {24'd0, bus.data_out}, 32'h11);
    end
    chk("drained_empty", {31'd0, bus.fifo_empty}, 32'd1);
    chk("last_pop",      {24'd0, bus.data_out}, 32'h10);

    // Push+pop on empty: push only, no read-through.
    both_w(8'h5A);
    chk("udr_set",      {31'd0, bus.underrun}, 32'd1);
    chk("udr_count",    {27'd0, bus.count}, 32'd1);
    chk("udr_no_rv",    {31'd0, bus.rd_valid}, 32'd0);
    chk("udr_dout_hold",{24'd0, bus.data_out}, 32'h10);
    pop_w();
    chk("pop_5a",       {24'd0, bus.data_out}, 32'h5A);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    chk("udr_evt_wins", {31'd0, bus.underrun}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("udr_clr",      {31'd0, bus.underrun}, 32'd0);

    // Steady state at count 8 with pointer wrap.
    for (int i = 0; i < 8; i++) push_w(8'h20 + 8'(i));
    for (int i = 0; i < 20; i++) both_w(8'h30 + 8'(i));
    chk("steady_count8", {27'd0, bus.count}, 32'd8);
    for (int i = 0; i < 8; i++) pop_w();
    chk("steady_tail",   {24'd0, bus.data_out}, 32'h43);

    // Push+pop while full keeps count at DEPTH without overrun.
    for (int i = 0; i < 16; i++) push_w(8'h40 + 8'(i));
    both_w(8'h99);
    chk("fullpp_count", {27'd0, bus.count}, 32'd16);
    chk("fullpp_ovr",   {31'd0, bus.overrun}, 32'd0);
    chk("fullpp_dout",  {24'd0, bus.data_out}, 32'h40);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("flush_full",   {27'd0, bus.count}, 32'd0);

    // Threshold trigger.
    bus.thresh = 5'd4;
    for (int i = 1; i <= 4; i++) begin
      push_w(8'(i));
      if (i == 3) chk("thr_at3", {31'd0, bus.thresh_hit}, 32'd0);
    end
    chk("thr_at4", {31'd0, bus.thresh_hit}, 32'd1);
    bus.thresh = 5'd0;
    #1;
    chk("thr_off", {31'd0, bus.thresh_hit}, 32'd0);
    push_w(8'h05);
    chk("count_5", {27'd0, bus.count}, 32'd5);

    // Flush beats a simultaneous push; data_out is untouched.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'hEE);
    chk("flush_count", {27'd0, bus.count}, 32'd0);
    chk("flush_empty", {31'd0, bus.fifo_empty}, 32'd1);
    chk("flush_dout",  {24'd0, bus.data_out}, 32'h40);

    // Asynchronous reset in the middle of a burst.
    push_w(8'h61);
    push_w(8'h62);
    push_w(8'h63);
    bus.push    = 1'b1;
    bus.data_in = 8'h64;
    rstn = 1'b0;
    #1;
    chk("mid_rst_count", {27'd0, bus.count}, 32'd0);
    chk("mid_rst_empty", {31'd0, bus.fifo_empty}, 32'd1);
    chk("mid_rst_dout",  {24'd0, bus.data_out}, 32'd0);
    bus.push = 1'b0;
    m_fifo.delete();
    exp_q.delete();
    m_cnt = 0;
    @(posedge clk_in);
    #2;
    rstn = 1'b1;
    @(posedge clk_in);
    #1;
    push_w(8'h77);
    pop_w();
    chk("post_rst_pop", {24'd0, bus.data_out}, 32'h77);

    repeat (3) @(posedge clk_in);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_fifo_param.md
UART_FIFO_PARAM -- requirements
Module: uart_fifo_param

Interface
REQ-001 Parameter DATA_W, default 8: entry width in bits (>=1).
REQ-002 Parameter DEPTH, default 16: entry count; power of two, >=2.
REQ-003 Derived constant AW = log2(DEPTH); count-width CW = AW+1.
REQ-004 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 push  input  1  write request; data_in captured when accepted.
REQ-007 pop  input  1  read request; head entry moved to data_out when accepted.
REQ-008 flush  input  1  synchronous clear of contents, pointers and count.
REQ-009 data_in  input  DATA_W  write data.
REQ-010 thresh  input  CW  trigger level for thresh_hit (0 disables).
REQ-011 clr_err  input  1  clears overrun and underrun sticky flags.
REQ-012 data_out  output  DATA_W  registered read data; holds until next accepted pop.
REQ-013 rd_valid  output  1  one-cycle pulse, the cycle after an accepted pop.
REQ-014 fifo_empty  output  1  count == 0.
REQ-015 fifo_full  output  1  count == DEPTH.
REQ-016 count  output  CW  current occupancy, 0..DEPTH.
REQ-017 almost_full  output  1  count >= DEPTH-1.
REQ-018 thresh_hit  output  1  thresh != 0 and count >= thresh.
REQ-019 overrun  output  1  sticky: push attempted while full and not popped.
REQ-020 underrun  output  1  sticky: pop attempted while empty.

Function
REQ-021 Storage SHALL be DEPTH x DATA_W with AW-bit write/read pointers wrapping DEPTH-1 -> 0 naturally.
REQ-022 Push alone SHALL be accepted iff count < DEPTH: write at wptr, wptr+1, count+1.
REQ-023 Pop alone SHALL be accepted iff count > 0: data_out <= mem[rptr], rptr+1, count-1, rd_valid=1 next cycle.
REQ-024 Push+pop with 0 < count < DEPTH SHALL accept both; count unchanged.
REQ-025 Push+pop when full SHALL accept both (pop frees the slot); count stays DEPTH; no overrun.
REQ-026 Push+pop when empty SHALL accept push only; pop ignored, underrun set, count becomes 1; no read-through.
REQ-027 Rejected push SHALL leave storage, pointers and count unchanged and set overrun.
REQ-028 Rejected pop SHALL leave data_out unchanged, rd_valid 0, and set underrun.
REQ-029 flush SHALL take priority over push/pop: pointers and count to 0 next cycle; data_out and flags unchanged.
REQ-030 clr_err SHALL clear flags next cycle; a new error event in the same cycle SHALL win (flag stays 1).
REQ-031 count SHALL never exceed DEPTH nor wrap below 0; all status outputs combinational from count.
REQ-032 Latency: pushed word visible on data_out one cycle after the pop that reads it; minimum push-to-pop spacing one cycle.

Reset
REQ-033 rstn low SHALL immediately force pointers, count, data_out (0), rd_valid, overrun, underrun to 0.
REQ-034 During reset: fifo_empty=1, fifo_full=0, almost_full=0, thresh_hit=0.
REQ-035 Storage array SHALL NOT require reset; contents undefined until written.
REQ-036 Reset mid-operation SHALL discard all entries; first post-reset push lands at address 0.

Structure
REQ-037 Shared package uart_pkg SHALL hold default DATA_W (8), DEPTH (16) and the log2 helper function.
REQ-038 One sub-module uart_fifo_ram (DATA_W x DEPTH, one write port, registered read) SHALL hold storage; control and flags stay in the top.

Verification
REQ-039 Reset, push 0x11..0x1F,0x10 (16 words) -> fifo_full=1, count=16, almost_full from count=15; 16 pops return same order, rd_valid each.
REQ-040 Full, push 0xAA alone -> overrun=1, count=16, 0xAA never popped; clr_err -> overrun=0.
REQ-041 Empty, push 0x5A with pop -> underrun=1, count=1; next pop -> data_out=0x5A.
REQ-042 count=8, push+pop for 20 cycles -> count stays 8, pointers wrap, output order preserved.
REQ-043 thresh=4: pushes 1..4 -> thresh_hit rises at count=4; thresh=0 -> thresh_hit=0.
REQ-044 count=5, flush with push -> count=0, fifo_empty=1; rstn low mid-burst -> all outputs at reset values same cycle.
